// File: rtl/laser_datapath.sv
// laser_datapath: range flag, Bresenham draw/erase rasteriser and cooldown timer for one tower.
// Optional build macro LASER_ALT_COLOUR_EN alternates the beam colour on every completed draw.
module laser_datapath #(
  parameter int         X_W          = 8,
  parameter int         Y_W          = 7,
  parameter int         RANGE        = 20,
  parameter int         DELAY_CYCLES = 50,
  parameter logic [2:0] LASER_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] ALT_COLOUR   = 3'b110
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           disabled,
  input  logic           wait_draw,
  input  logic           draw_laser,
  input  logic           erase,
  input  logic           delay,
  input  logic [X_W-1:0] tower_x,
  input  logic [Y_W-1:0] tower_y,
  input  logic [X_W-1:0] car_x,
  input  logic [Y_W-1:0] car_y,
  input  logic           car_valid,
  output logic           car_in_range,
  output logic           draw_done,
  output logic           drawn,
  output logic           erase_done,
  output logic           delay_done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  // state | meaning
  // IDLE  | waiting for a command from the control FSM
  // INIT  | load Bresenham terms from tower and saved endpoint
  // LINE  | plot one pixel per cycle while stepping toward the endpoint
  // DONE  | one-cycle draw_done/erase_done pulse, update drawn
  // HOLD  | wait for the originating command to drop
  // COUNT | cooldown down-counter running
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LINE  = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4,
    S_COUNT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'd0,
    C_DRAW  = 2'd1,
    C_ERASE = 2'd2,
    C_DELAY = 2'd3
  } cmd_t;

  localparam int MAX_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int ERR_W = MAX_W + 3;
  localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [X_W-1:0]          RANGE_X  = X_W'(RANGE);
  localparam logic [Y_W-1:0]          RANGE_Y  = Y_W'(RANGE);
  localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic signed [ERR_W-1:0] ERR_ZERO = '0;

  function automatic logic [X_W:0] diff_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [Y_W:0] diff_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [X_W-1:0] mag_x(input logic [X_W:0] d);
    return d[X_W] ? X_W'(-d) : d[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] mag_y(input logic [Y_W:0] d);
    return d[Y_W] ? Y_W'(-d) : d[Y_W-1:0];
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  cmd_t   r_cmd;
  cmd_t   w_cmd_nxt;

  logic                     r_drawn;
  logic                     r_in_range;
  logic [X_W-1:0]           r_end_x;
  logic [Y_W-1:0]           r_end_y;
  logic [X_W-1:0]           r_cur_x;
  logic [Y_W-1:0]           r_cur_y;
  logic [X_W-1:0]           r_dx;
  logic [Y_W-1:0]           r_dy;
  logic                     r_sx;
  logic                     r_sy;
  logic signed [ERR_W-1:0]  r_err;
  logic [CNT_W-1:0]         r_cnt;

  logic                     w_cmd_active;
  logic                     w_at_end;
  logic                     w_cnt_zero;
  logic                     w_in_range;
  logic                     w_load_end;
  logic                     w_load_cnt;
  logic                     w_set_drawn;
  logic                     w_clr_drawn;
  logic                     w_plot;
  logic                     w_draw_pulse;
  logic                     w_erase_pulse;
  logic                     w_delay_pulse;
  logic [X_W:0]             w_ddx;
  logic [Y_W:0]             w_ddy;
  logic [X_W-1:0]           w_ldx;
  logic [Y_W-1:0]           w_ldy;
  logic signed [ERR_W-1:0]  w_dx_e;
  logic signed [ERR_W-1:0]  w_dy_e;
  logic signed [ERR_W-1:0]  w_ndy;
  logic signed [ERR_W-1:0]  w_e2;
  logic signed [ERR_W-1:0]  w_err_nxt;
  logic                     w_step_x;
  logic                     w_step_y;
  logic [2:0]               w_draw_colour;
  logic                     w_unused_wait;

  // wait_draw carries no datapath work; the tower FSM decides when to draw
  assign w_unused_wait = wait_draw;

  assign w_in_range = car_valid
                    && (mag_x(diff_x(car_x, tower_x)) <= RANGE_X)
                    && (mag_y(diff_y(car_y, tower_y)) <= RANGE_Y);

  assign w_cmd_active = ((r_cmd == C_DRAW)  && draw_laser)
                     || ((r_cmd == C_ERASE) && erase)
                     || ((r_cmd == C_DELAY) && delay);

  assign w_at_end   = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);
  assign w_cnt_zero = (r_cnt == '0);

  assign w_ddx = diff_x(r_end_x, tower_x);
  assign w_ddy = diff_y(r_end_y, tower_y);
  assign w_ldx = mag_x(w_ddx);
  assign w_ldy = mag_y(w_ddy);

  // error term e = dx - dy; x steps when 2e > -dy, y steps when 2e < dx
  assign w_dx_e    = ERR_W'(r_dx);
  assign w_dy_e    = ERR_W'(r_dy);
  assign w_ndy     = -w_dy_e;
  assign w_e2      = r_err <<< 1;
  assign w_step_x  = (w_e2 > w_ndy);
  assign w_step_y  = (w_e2 < w_dx_e);
  assign w_err_nxt = r_err - (w_step_x ? w_dy_e : ERR_ZERO) + (w_step_y ? w_dx_e : ERR_ZERO);

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_load_end    = 1'b0;
    w_load_cnt    = 1'b0;
    w_set_drawn   = 1'b0;
    w_clr_drawn   = 1'b0;
    w_plot        = 1'b0;
    w_draw_pulse  = 1'b0;
    w_erase_pulse = 1'b0;
    w_delay_pulse = 1'b0;
    if (disabled) begin
      w_state_nxt = S_IDLE;
      w_cmd_nxt   = C_NONE;
      w_clr_drawn = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (erase) begin
            w_cmd_nxt   = C_ERASE;
            w_state_nxt = r_drawn ? S_INIT : S_DONE;
          end else if (draw_laser) begin
            w_cmd_nxt   = C_DRAW;
            w_load_end  = 1'b1;
            w_state_nxt = S_INIT;
          end else if (delay) begin
            w_cmd_nxt   = C_DELAY;
            w_load_cnt  = 1'b1;
            w_state_nxt = S_COUNT;
          end
        end
        S_INIT: begin
          w_state_nxt = w_cmd_active ? S_LINE : S_IDLE;
        end
        S_LINE: begin
          w_plot = 1'b1;
          if (!w_cmd_active) begin
            w_state_nxt = S_IDLE;
          end else if (w_at_end) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (r_cmd == C_ERASE) begin
            w_erase_pulse = 1'b1;
            w_clr_drawn   = 1'b1;
          end else begin
            w_draw_pulse  = 1'b1;
            w_set_drawn   = 1'b1;
          end
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!w_cmd_active) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_COUNT: begin
          if (!w_cmd_active) begin
            w_state_nxt = S_IDLE;
          end else if (w_cnt_zero) begin
            w_delay_pulse = 1'b1;
            w_state_nxt   = S_HOLD;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cmd   <= C_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drawn    <= 1'b0;
      r_in_range <= 1'b0;
      r_end_x    <= '0;
      r_end_y    <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_err      <= '0;
      r_cnt      <= '0;
    end else begin
      r_in_range <= w_in_range;
      if (w_load_end) begin
        r_end_x <= car_x;
        r_end_y <= car_y;
      end
      if (w_set_drawn) begin
        r_drawn <= 1'b1;
      end else if (w_clr_drawn) begin
        r_drawn <= 1'b0;
      end
      if (r_state == S_INIT) begin
        r_cur_x <= tower_x;
        r_cur_y <= tower_y;
        r_dx    <= w_ldx;
        r_dy    <= w_ldy;
        r_sx    <= w_ddx[X_W];
        r_sy    <= w_ddy[Y_W];
        r_err   <= ERR_W'(w_ldx) - ERR_W'(w_ldy);
      end else if (r_state == S_LINE) begin
        if (w_step_x) begin
          r_cur_x <= r_sx ? (r_cur_x - X_W'(1)) : (r_cur_x + X_W'(1));
        end
        if (w_step_y) begin
          r_cur_y <= r_sy ? (r_cur_y - Y_W'(1)) : (r_cur_y + Y_W'(1));
        end
        r_err <= w_err_nxt;
      end
      if (w_load_cnt) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == S_COUNT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

`ifdef LASER_ALT_COLOUR_EN
  logic r_alt_sel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_alt_sel <= 1'b0;
    end else if (w_draw_pulse) begin
      r_alt_sel <= ~r_alt_sel;
    end
  end

  assign w_draw_colour = r_alt_sel ? ALT_COLOUR : LASER_COLOUR;
`else
  logic w_unused_alt;

  assign w_unused_alt  = ^ALT_COLOUR;
  assign w_draw_colour = LASER_COLOUR;
`endif

  // pixel bus is forced to zero whenever no write is strobed
  assign vga_plot     = w_plot;
  assign vga_x        = w_plot ? r_cur_x : '0;
  assign vga_y        = w_plot ? r_cur_y : '0;
  assign vga_colour   = w_plot ? ((r_cmd == C_ERASE) ? BG_COLOUR : w_draw_colour) : 3'b000;
  assign draw_done    = w_draw_pulse;
  assign erase_done   = w_erase_pulse;
  assign delay_done   = w_delay_pulse;
  assign drawn        = r_drawn;
  assign car_in_range = r_in_range;

endmodule
